// File: rtl/aes_check_pkg.sv
// rtl/aes_check_pkg.sv - shared state type and bring-up vectors for the AES result checker
package aes_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [127:0] KEY_DEFAULT = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] EXP_DEFAULT = 128'h4b286e22c5d2113d01227cc2cdf88f39;

endpackage

// File: rtl/aes_seg_match.sv
// rtl/aes_seg_match.sv - per-segment equality compare of result against expected vector
module aes_seg_match #(
  parameter int DATA_W = 128,
  parameter int SEG_W  = 8
) (
  input  logic [DATA_W-1:0]       i_res,
  input  logic [DATA_W-1:0]       i_exp,
  output logic [DATA_W/SEG_W-1:0] o_match
);

  localparam int NSEG = DATA_W / SEG_W;

  always_comb begin
    o_match = '0;
    for (int i = 0; i < NSEG; i++) begin
      o_match[i] = (i_res[i*SEG_W +: SEG_W] == i_exp[i*SEG_W +: SEG_W]);
    end
  end

endmodule

// File: rtl/aes_result_checker.sv
// rtl/aes_result_checker.sv - streaming self-check of AES results with pass/fail counts and LED verdict
// Optional idle timeout in RUN is built only when CHECKER_TIMEOUT_EN is defined.
module aes_result_checker
  import aes_check_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int SEG_W   = 8,
  parameter int NUM_VEC = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           res_valid,
  input  logic [DATA_W-1:0]              res_data,
  input  logic [DATA_W-1:0]              exp_data,
  output logic                           res_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [DATA_W/SEG_W-1:0]        match_mask,
  output logic [$clog2(NUM_VEC+1)-1:0]   pass_cnt,
  output logic [$clog2(NUM_VEC+1)-1:0]   fail_cnt,
  output logic                           timeout,
  output logic [DATA_W/SEG_W-1:0]        led
);

  localparam int NSEG  = DATA_W / SEG_W;
  localparam int CNT_W = $clog2(NUM_VEC + 1);

  state_t            r_state;
  state_t            w_next;
  logic [NSEG-1:0]   w_seg;
  logic [NSEG-1:0]   r_match_mask;
  logic [NSEG-1:0]   r_fail_mask;
  logic [CNT_W-1:0]  r_pass_cnt;
  logic [CNT_W-1:0]  r_fail_cnt;
  logic [CNT_W-1:0]  r_vec_idx;
  logic              w_accept;
  logic              w_last;
  logic              w_start_run;
  logic              w_timeout_fire;

  aes_seg_match #(
    .DATA_W (DATA_W),
    .SEG_W  (SEG_W)
  ) u_seg_match (
    .i_res   (res_data),
    .i_exp   (exp_data),
    .o_match (w_seg)
  );

  assign w_accept    = res_valid && (r_state == RUN);
  assign w_last      = w_accept && (r_vec_idx == CNT_W'(NUM_VEC - 1));
  assign w_start_run = start && (r_state != RUN);

`ifdef CHECKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 2);
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_timeout;

  // An accept in the expiry cycle takes priority over the timeout.
  assign w_timeout_fire = (r_state == RUN) && !w_accept && (r_idle_cnt == IDLE_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_start_run) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_accept) begin
      r_idle_cnt <= '0;
    end else if (w_timeout_fire) begin
      r_timeout  <= 1'b1;
    end else if (r_state == RUN) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout_fire   = 1'b0;
  assign timeout          = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last || w_timeout_fire) w_next = DONE;
      DONE:    if (start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_match_mask <= '0;
      r_fail_mask  <= '0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_vec_idx    <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_run) begin
        r_match_mask <= '0;
        r_fail_mask  <= '0;
        r_pass_cnt   <= '0;
        r_fail_cnt   <= '0;
        r_vec_idx    <= '0;
      end else if (w_accept) begin
        r_match_mask <= w_seg;
        r_vec_idx    <= r_vec_idx + CNT_W'(1);
        if (&w_seg) begin
          r_pass_cnt <= r_pass_cnt + CNT_W'(1);
        end else begin
          r_fail_cnt <= r_fail_cnt + CNT_W'(1);
          // Only the first failing result of a run is kept for the LEDs.
          if (r_fail_cnt == '0) r_fail_mask <= w_seg;
        end
      end
    end
  end

  assign res_ready  = (r_state == RUN);
  assign busy       = res_ready;
  assign done       = (r_state == DONE);
  assign pass       = done && (r_fail_cnt == '0) && !timeout;
  assign match_mask = r_match_mask;
  assign pass_cnt   = r_pass_cnt;
  assign fail_cnt   = r_fail_cnt;

  always_comb begin
    led = '0;
    case (r_state)
      RUN:     led = r_match_mask;
      DONE:    begin
        if (pass)                  led = '1;
        else if (r_fail_cnt != '0) led = r_fail_mask;
      end
      default: led = '0;
    endcase
  end

endmodule

// File: tb/tb_aes_result_checker.sv
// tb/tb_aes_result_checker.sv - self-checking bench for aes_result_checker (timeout case needs CHECKER_TIMEOUT_EN)
module tb_aes_result_checker;
  import aes_check_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic         res_valid = 1'b0;
  logic [127:0] res_data = '0;
  logic [127:0] exp_data = '0;

  logic         a_ready, a_busy, a_done, a_pass, a_to;
  logic [15:0]  a_mask, a_led;
  logic [0:0]   a_pcnt, a_fcnt;
  logic         b_ready, b_busy, b_done, b_pass, b_to;
  logic [15:0]  b_mask, b_led;
  logic [2:0]   b_pcnt, b_fcnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aes_result_checker #(.DATA_W(128), .SEG_W(8), .NUM_VEC(1), .TIMEOUT(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .res_valid(res_valid),
    .res_data(res_data), .exp_data(exp_data), .res_ready(a_ready), .busy(a_busy),
    .done(a_done), .pass(a_pass), .match_mask(a_mask), .pass_cnt(a_pcnt),
    .fail_cnt(a_fcnt), .timeout(a_to), .led(a_led)
  );

  aes_result_checker #(.DATA_W(128), .SEG_W(8), .NUM_VEC(4), .TIMEOUT(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .res_valid(res_valid),
    .res_data(res_data), .exp_data(exp_data), .res_ready(b_ready), .busy(b_busy),
    .done(b_done), .pass(b_pass), .match_mask(b_mask), .pass_cnt(b_pcnt),
    .fail_cnt(b_fcnt), .timeout(b_to), .led(b_led)
  );

  typedef struct {
    logic [127:0] res;
    logic [127:0] exp;
    logic [15:0]  mask;
    logic         pass;
    logic [15:0]  led;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  task automatic send(input logic [127:0] r, input logic [127:0] e);
    res_valid = 1'b1;
    res_data  = r;
    exp_data  = e;
    tick();
    res_valid = 1'b0;
  endtask

  // Reference: byte i matches when the two 8-bit fields extracted arithmetically agree.
  function automatic logic [15:0] ref_mask(input logic [127:0] r, input logic [127:0] e);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      m[i] = (((r >> (8 * i)) & 128'hFF) == ((e >> (8 * i)) & 128'hFF));
    end
    return m;
  endfunction

  initial begin #2000000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    vec_t         tbl[4];
    logic [127:0] r, e;
    logic [15:0]  m, first_fail;
    int           pc, fc, k;

    tbl[0] = '{EXP_DEFAULT, EXP_DEFAULT, 16'hFFFF, 1'b1, 16'hFFFF};
    tbl[1] = '{EXP_DEFAULT ^ 128'h01, EXP_DEFAULT, 16'hFFFE, 1'b0, 16'hFFFE};
    tbl[2] = '{~EXP_DEFAULT, EXP_DEFAULT, 16'h0000, 1'b0, 16'h0000};
    tbl[3] = '{EXP_DEFAULT ^ 128'h01000000_00000000_80000000_00000000, EXP_DEFAULT, 16'h7F7F, 1'b0, 16'h7F7F};

    #1;
    check("rst_ready", b_ready, 0);
    check("rst_done", b_done, 0);
    check("rst_pcnt", b_pcnt, 0);
    check("rst_led", b_led, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", a_busy, 0);
    check("idle_led", a_led, 0);

    for (int i = 0; i < 4; i++) begin
      pulse_a();
      check($sformatf("t%0d_busy", i), a_busy, 1);
      check($sformatf("t%0d_clr", i), a_pcnt + a_fcnt, 0);
      send(tbl[i].res, tbl[i].exp);
      check($sformatf("t%0d_done", i), a_done, 1);
      check($sformatf("t%0d_ready", i), a_ready, 0);
      check($sformatf("t%0d_pass", i), a_pass, tbl[i].pass);
      check($sformatf("t%0d_mask", i), a_mask, tbl[i].mask);
      check($sformatf("t%0d_pcnt", i), a_pcnt, tbl[i].pass ? 1 : 0);
      check($sformatf("t%0d_fcnt", i), a_fcnt, tbl[i].pass ? 0 : 1);
      check($sformatf("t%0d_led", i), a_led, tbl[i].led);
    end

    // Four back-to-back results: third has byte 15 wrong, fourth byte 0 wrong.
    pulse_b();
    res_valid = 1'b1;
    exp_data  = EXP_DEFAULT;
    for (int v = 0; v < 4; v++) begin
      res_data = EXP_DEFAULT;
      if (v == 2) res_data = EXP_DEFAULT ^ 128'hFF000000_00000000_00000000_00000000;
      if (v == 3) res_data = EXP_DEFAULT ^ 128'h01;
      if (v < 3) check($sformatf("b2b_ready%0d", v), b_ready, 1);
      tick();
      if (v < 3) check($sformatf("b2b_notdone%0d", v), b_done, 0);
    end
    res_valid = 1'b0;
    check("b2b_done", b_done, 1);
    check("b2b_pcnt", b_pcnt, 2);
    check("b2b_fcnt", b_fcnt, 2);
    check("b2b_mask", b_mask, 16'hFFFE);
    check("b2b_led", b_led, 16'h7FFF);
    check("b2b_pass", b_pass, 0);

    // Randomised runs against the reference model, with short gaps between results.
    for (int run = 0; run < 6; run++) begin
      pulse_b();
      pc = 0; fc = 0; first_fail = '0;
      for (int v = 0; v < 4; v++) begin
        repeat ($urandom_range(0, 3)) tick();
        e = {$urandom, $urandom, $urandom, $urandom};
        r = e;
        for (int s = 0; s < 16; s++) begin
          if ($urandom_range(0, 9) == 0) r = r ^ (128'($urandom_range(1, 255)) << (8 * s));
        end
        send(r, e);
        m = ref_mask(r, e);
        if (m == 16'hFFFF) pc++;
        else begin
          if (fc == 0) first_fail = m;
          fc++;
        end
        check($sformatf("rnd%0d_%0d_mask", run, v), b_mask, m);
        check($sformatf("rnd%0d_%0d_done", run, v), b_done, (v == 3) ? 1 : 0);
      end
      check($sformatf("rnd%0d_pcnt", run), b_pcnt, pc);
      check($sformatf("rnd%0d_fcnt", run), b_fcnt, fc);
      check($sformatf("rnd%0d_pass", run), b_pass, (fc == 0) ? 1 : 0);
      check($sformatf("rnd%0d_led", run), b_led, (fc == 0) ? 16'hFFFF : first_fail);
    end

    // start with res_valid in DONE: no accept, counts cleared, run begins.
    start_b   = 1'b1;
    res_valid = 1'b1;
    res_data  = EXP_DEFAULT;
    exp_data  = EXP_DEFAULT;
    tick();
    start_b   = 1'b0;
    res_valid = 1'b0;
    check("dstart_busy", b_busy, 1);
    check("dstart_pcnt", b_pcnt, 0);
    check("dstart_fcnt", b_fcnt, 0);
    check("dstart_mask", b_mask, 0);
    send(EXP_DEFAULT, EXP_DEFAULT);
    send(EXP_DEFAULT, EXP_DEFAULT);
    pulse_b();
    check("rstart_busy", b_busy, 1);
    check("rstart_pcnt", b_pcnt, 2);
    send(EXP_DEFAULT, EXP_DEFAULT);
    send(EXP_DEFAULT, EXP_DEFAULT);
    check("rstart_done", b_done, 1);
    check("rstart_pcnt4", b_pcnt, 4);

    // Reset in the middle of a run.
    pulse_b();
    send(EXP_DEFAULT, EXP_DEFAULT);
    check("mid_pcnt", b_pcnt, 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy", b_busy, 0);
    check("mid_rst_ready", b_ready, 0);
    check("mid_rst_pcnt", b_pcnt, 0);
    check("mid_rst_mask", b_mask, 0);
    check("mid_rst_led", b_led, 0);
    check("mid_rst_a_done", a_done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", b_busy, 0);
    pulse_b();
    for (int v = 0; v < 4; v++) send(EXP_DEFAULT, EXP_DEFAULT);
    check("post_rst_pcnt", b_pcnt, 4);
    check("post_rst_fcnt", b_fcnt, 0);
    check("post_rst_pass", b_pass, 1);
    check("post_rst_led", b_led, 16'hFFFF);

`ifdef CHECKER_TIMEOUT_EN
    pulse_b();
    send(EXP_DEFAULT, EXP_DEFAULT);
    k = 0;
    while (!b_done && k < 40) begin
      tick();
      k++;
    end
    check("to_latency", k, 17);
    check("to_done", b_done, 1);
    check("to_flag", b_to, 1);
    check("to_pass", b_pass, 0);
    check("to_pcnt", b_pcnt, 1);
    check("to_led", b_led, 0);
`else
    pulse_b();
    send(EXP_DEFAULT, EXP_DEFAULT);
    k = 0;
    repeat (40) begin
      tick();
      k++;
    end
    check("noto_busy", b_busy, 1);
    check("noto_flag", b_to, 0);
    check("noto_pcnt", b_pcnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_result_checker.md
# aes_result_checker

Parametrised on-chip self-check for the AES datapath. It accepts a stream of NUM_VEC cipher results from the encrypt core over a valid/ready handshake, compares each against an expected vector segment by segment, and keeps pass/fail counts. It latches the first failing segment mask and drives a board LED bank with the verdict. It sits between the AES core and the FPGA top level and supersedes the fixed single-vector, purely combinational LED compare.

## Interface
Parameters:
- DATA_W, 128, width of result and expected vectors
- SEG_W, 8, bits per compared segment; DATA_W must be a multiple of SEG_W; NSEG = DATA_W/SEG_W
- NUM_VEC, 1, results checked per run; must be ≥ 1
- TIMEOUT, 1024, maximum idle cycles in RUN between accepts, used only with CHECKER_TIMEOUT_EN

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new run (single-cycle pulse)
- res_valid  in  1  result from AES core valid
- res_data  in  DATA_W  cipher result
- exp_data  in  DATA_W  expected value for the current result, sampled with res_data
- res_ready  out  1  checker accepts a result
- busy  out  1  run in progress
- done  out  1  run finished (level)
- pass  out  1  all results matched and no timeout; valid while done=1
- match_mask  out  NSEG  per-segment match of the last accepted result
- pass_cnt, fail_cnt  out  CNT_W = $clog2(NUM_VEC+1)  result counts for the run
- timeout  out  1  run ended by timeout
- led  out  NSEG  board indicator

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE when the NUM_VEC-th result is accepted, or when the timeout fires.
  - DONE→RUN on start.
- Starting a run clears pass_cnt, fail_cnt, match_mask, fail_mask, timeout, vec_idx and the idle counter.
- start in RUN is ignored.
- res_ready = (state==RUN); busy = res_ready; done = (state==DONE).
- Accept when res_valid && res_ready.
- Per accepted result:
  - seg[i] = (res_data[i*SEG_W +: SEG_W] == exp_data[i*SEG_W +: SEG_W]).
  - match_mask <= seg.
  - If seg is all ones, pass_cnt+1; otherwise fail_cnt+1.
  - On the first mismatch of the run, latch fail_mask <= seg (sticky).
  - vec_idx increments.
- pass = done && fail_cnt==0 && !timeout.
- led:
  - IDLE: 0.
  - RUN: match_mask.
  - DONE with pass: all ones.
  - DONE with a failure: fail_mask.
  - DONE by timeout with no failure: 0.
- Counters never wrap; pass_cnt + fail_cnt ≤ NUM_VEC by construction.

## Timing
- Reset: state IDLE; every output 0, including led, res_ready and counters.
- Reset asserted mid-run aborts immediately to IDLE and clears everything; no partial result is retained.
- Accept at edge N: match_mask, counts and led update at edge N; done rises at edge N when N is the last accept (visible the cycle after the handshake).
- Back-to-back accepts allowed, one per cycle; res_ready stays high through RUN with no bubble.
- start and res_valid in the same IDLE/DONE cycle: the result is not accepted (res_ready=0); RUN begins next cycle.
- Timeout: an idle counter increments each RUN cycle without an accept and resets on accept. When it reaches TIMEOUT, the FSM goes to DONE at the next edge with timeout=1.
- An accept and timeout expiry in the same cycle: the accept wins and the counter resets.

## Configuration
- CHECKER_TIMEOUT_EN defined: idle counter, timeout flag and timeout transition are present.
- CHECKER_TIMEOUT_EN undefined: no counter is built, timeout is tied 0, and RUN waits indefinitely for NUM_VEC results.

## Structure
- Package aes_check_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the FIPS-197-style bring-up constants: KEY_DEFAULT = 128'h100F0E0D0C0B0A090807060504030201 and EXP_DEFAULT = 128'h4b286e22c5d2113d01227cc2cdf88f39.
- Sub-module aes_seg_match: combinational, parametrised by DATA_W and SEG_W, produces the NSEG match vector; the checker instantiates it once.

## Test plan
- Reset, then NUM_VEC=1, start, result EXP_DEFAULT against EXP_DEFAULT -> done=1, pass=1, pass_cnt=1, fail_cnt=0, led=16'hFFFF.
- NUM_VEC=1, result with byte 0 = 8'h38 (expected 8'h39) -> pass=0, fail_cnt=1, match_mask=16'hFFFE, led=16'hFFFE.
- NUM_VEC=4, back-to-back valid over 4 cycles; vector 2 has byte 15 wrong, vector 3 has byte 0 wrong -> done exactly one cycle after the 4th handshake, pass_cnt=2, fail_cnt=2, led=16'h7FFF (first failure sticky).
- CHECKER_TIMEOUT_EN, TIMEOUT=16, NUM_VEC=2, only one correct result sent -> done=1, timeout=1, pass=0, pass_cnt=1, led=0, reached 16 idle cycles after the accept.
- rst_n pulled low mid-run after 1 of 3 accepts, then released and start reissued -> all outputs 0 during reset; the new run completes with fresh counts (pass_cnt=3).
- start pulse during RUN and start coincident with res_valid in DONE -> run not restarted; no result accepted in the DONE cycle; counts cleared next cycle.
